// File: rtl/ddr_ring_buffer_pkg.sv
// ddr_ring_buffer_pkg: shared output-state enum and pack-geometry helpers
//   pack_ratio(aw, iw) -> number of input lanes per packed word (R)
//   fill_width(aw, iw) -> width of the staged-lane counter ($clog2(R)+1)
package ddr_ring_buffer_pkg;
    typedef enum logic {IDLE, VALID} out_state_e;
    function automatic int pack_ratio(input int aw, input int iw);
        return aw / iw;
    endfunction
    function automatic int fill_width(input int aw, input int iw);
        return $clog2(aw / iw) + 1;
    endfunction
endpackage

// File: rtl/ddr_ring_buffer_ingress_packer.sv
// ddr_ring_buffer_ingress_packer: stages input beats into lanes of one packed word
//   clk, clr       : clock, synchronous active-high flush of staged lanes
//   beat, s_tdata  : accepted input handshake and its data
//   s_tlast        : last flag of the accepted beat (closes the word early)
//   word, complete : packed word including the current beat, valid when complete=1
//   pack_fill      : number of lanes currently staged
module ddr_ring_buffer_ingress_packer
    import ddr_ring_buffer_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int IN_WIDTH = 8,
    localparam int R = pack_ratio(AXI_DATA_WIDTH, IN_WIDTH),
    localparam int FW = fill_width(AXI_DATA_WIDTH, IN_WIDTH)
)(
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      beat,
    input  logic [IN_WIDTH-1:0]       s_tdata,
    input  logic                      s_tlast,
    output logic [AXI_DATA_WIDTH-1:0] word,
    output logic                      complete,
    output logic [FW-1:0]             pack_fill
);
    logic [AXI_DATA_WIDTH-1:0] stage;
    logic [FW-1:0]             lane;
    // Stage is cleared after every completed word, so unfilled lanes are already zero.
    always_comb begin
        word = stage;
        word[int'(lane) * IN_WIDTH +: IN_WIDTH] = s_tdata;
        complete = beat & (s_tlast | (lane == FW'(R - 1)));
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            stage <= '0;
            lane  <= '0;
        end else if (beat) begin
            stage <= complete ? '0 : word;
            lane  <= complete ? '0 : lane + FW'(1);
        end
    end
    assign pack_fill = lane;
endmodule

// File: rtl/ddr_ring_buffer_ingress.sv
// ddr_ring_buffer_ingress: packs narrow input beats into wide words for the ring buffer core
//   clk, rst, soft_rst              : clock, sync active-high reset and datapath flush
//   s_tdata/s_tvalid/s_tlast/s_tready : narrow input stream
//   m_tdata/m_tvalid/m_tlast/m_tready : packed output stream
//   write_offset                    : words handed over since the last end-of-block
//   ddr_eob, clear_eob              : sticky end-of-block flag and its clear
//   data_loss, drop_count           : overflow status (active only with DDR_RING_BUFFER_INGRESS_DROP_EN)
//   pack_fill                       : number of lanes currently staged
//   Macro DDR_RING_BUFFER_INGRESS_DROP_EN: never backpressure; drop words completed while stalled.
module ddr_ring_buffer_ingress
    import ddr_ring_buffer_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int IN_WIDTH = 8,
    parameter int DROP_CNT_WIDTH = 16,
    localparam int FW = fill_width(AXI_DATA_WIDTH, IN_WIDTH)
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      soft_rst,
    input  logic [IN_WIDTH-1:0]       s_tdata,
    input  logic                      s_tvalid,
    input  logic                      s_tlast,
    output logic                      s_tready,
    output logic [AXI_DATA_WIDTH-1:0] m_tdata,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic [31:0]               write_offset,
    output logic                      ddr_eob,
    input  logic                      clear_eob,
    output logic                      data_loss,
    output logic [DROP_CNT_WIDTH-1:0] drop_count,
    output logic [FW-1:0]             pack_fill
);
    logic                      clr, beat, complete, load, m_hs;
    logic [AXI_DATA_WIDTH-1:0] word;
    out_state_e                state, state_nxt;
    assign clr = rst | soft_rst;
    assign beat = s_tvalid & s_tready;
    assign load = complete & (!m_tvalid | m_tready);
    assign m_hs = m_tvalid & m_tready;
    assign m_tvalid = state == VALID;
    ddr_ring_buffer_ingress_packer #(
        .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
        .IN_WIDTH(IN_WIDTH)
    ) u_packer (
        .clk(clk),
        .clr(clr),
        .beat(beat),
        .s_tdata(s_tdata),
        .s_tlast(s_tlast),
        .word(word),
        .complete(complete),
        .pack_fill(pack_fill)
    );
    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end
    // A new word keeps VALID; otherwise VALID drains only when the consumer takes it.
    always_comb begin
        state_nxt = (state == IDLE) ? (load ? VALID : IDLE) : ((load || !m_tready) ? VALID : IDLE);
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            m_tdata <= '0;
            m_tlast <= 1'b0;
        end else if (load) begin
            m_tdata <= word;
            m_tlast <= s_tlast;
        end
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            write_offset <= '0;
            ddr_eob      <= 1'b0;
        end else begin
            if (m_hs) write_offset <= m_tlast ? '0 : write_offset + 32'd1;
            if (m_hs && m_tlast) ddr_eob <= 1'b1;
            else if (clear_eob)  ddr_eob <= 1'b0;
        end
    end
`ifdef DDR_RING_BUFFER_INGRESS_DROP_EN
    logic drop;
    assign s_tready = !clr;
    assign drop = complete & m_tvalid & !m_tready;
    always_ff @(posedge clk) begin
        if (clr) begin
            data_loss  <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            data_loss  <= 1'b1;
            drop_count <= (drop_count == '1) ? drop_count : drop_count + DROP_CNT_WIDTH'(1);
        end
    end
`else
    assign s_tready = !clr & (!m_tvalid | m_tready);
    assign data_loss = 1'b0;
    assign drop_count = '0;
`endif
endmodule

// File: tb/tb_ddr_ring_buffer_ingress.sv
// tb_ddr_ring_buffer_ingress: directed and randomized checks of the beat packer
module tb_ddr_ring_buffer_ingress;
    localparam int AW = 32, IW = 8, R = 4, DW = 16, FW = 3;
    logic clk = 1'b0;
    logic rst, soft_rst, s_tvalid, s_tlast, s_tready, m_tvalid, m_tlast, m_tready;
    logic ddr_eob, clear_eob, data_loss;
    logic [IW-1:0] s_tdata;
    logic [AW-1:0] m_tdata;
    logic [31:0]   write_offset;
    logic [DW-1:0] drop_count;
    logic [FW-1:0] pack_fill;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    ddr_ring_buffer_ingress #(.AXI_DATA_WIDTH(AW), .IN_WIDTH(IW), .DROP_CNT_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .soft_rst(soft_rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .write_offset(write_offset), .ddr_eob(ddr_eob), .clear_eob(clear_eob),
        .data_loss(data_loss), .drop_count(drop_count), .pack_fill(pack_fill)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Called at a falling edge: drive inputs, return at the next falling edge.
    task automatic cycle(input logic v, input logic [IW-1:0] d, input logic l, input logic r);
        s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = r;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid got=%0h exp=0", m_tvalid); end
        n_chk++; if (m_tdata !== 32'h0) begin n_fail++; $display("FAIL reset_m_tdata got=%0h exp=0", m_tdata); end
        n_chk++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_m_tlast got=%0h exp=0", m_tlast); end
        n_chk++; if (pack_fill !== 3'd0) begin n_fail++; $display("FAIL reset_pack_fill got=%0d exp=0", pack_fill); end
        n_chk++; if (write_offset !== 32'd0) begin n_fail++; $display("FAIL reset_write_offset got=%0h exp=0", write_offset); end
        n_chk++; if (ddr_eob !== 1'b0) begin n_fail++; $display("FAIL reset_ddr_eob got=%0h exp=0", ddr_eob); end
        n_chk++; if (data_loss !== 1'b0) begin n_fail++; $display("FAIL reset_data_loss got=%0h exp=0", data_loss); end
        n_chk++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop_count got=%0h exp=0", drop_count); end
        n_chk++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL reset_s_tready got=%0h exp=0", s_tready); end
        rst = 1'b0;
        #1;
        n_chk++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL post_reset_s_tready got=%0h exp=1", s_tready); end
        @(negedge clk);
    endtask

    task automatic test_pack();
        cycle(1, 8'h11, 0, 1);
        cycle(1, 8'h22, 0, 1);
        n_chk++; if (pack_fill !== 3'd2) begin n_fail++; $display("FAIL pack_fill_mid got=%0d exp=2", pack_fill); end
        cycle(1, 8'h33, 0, 1);
        cycle(1, 8'h44, 0, 1);
        n_chk++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL pack_m_tvalid got=%0h exp=1", m_tvalid); end
        n_chk++; if (m_tdata !== 32'h44332211) begin n_fail++; $display("FAIL pack_m_tdata got=%0h exp=44332211", m_tdata); end
        n_chk++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL pack_m_tlast got=%0h exp=0", m_tlast); end
        n_chk++; if (pack_fill !== 3'd0) begin n_fail++; $display("FAIL pack_fill_done got=%0d exp=0", pack_fill); end
        cycle(0, 0, 0, 1);
        n_chk++; if (write_offset !== 32'd1) begin n_fail++; $display("FAIL pack_write_offset got=%0h exp=1", write_offset); end
        n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL pack_drain got=%0h exp=0", m_tvalid); end
    endtask

    task automatic test_tlast();
        cycle(1, 8'hAA, 0, 1);
        cycle(1, 8'hBB, 1, 1);
        n_chk++; if (m_tdata !== 32'h0000BBAA) begin n_fail++; $display("FAIL tlast_m_tdata got=%0h exp=0000bbaa", m_tdata); end
        n_chk++; if (m_tlast !== 1'b1) begin n_fail++; $display("FAIL tlast_m_tlast got=%0h exp=1", m_tlast); end
        cycle(0, 0, 0, 1);
        n_chk++; if (write_offset !== 32'd0) begin n_fail++; $display("FAIL tlast_write_offset got=%0h exp=0", write_offset); end
        n_chk++; if (ddr_eob !== 1'b1) begin n_fail++; $display("FAIL tlast_ddr_eob got=%0h exp=1", ddr_eob); end
    endtask

    task automatic test_eob_clear();
        cycle(1, 8'h05, 1, 1);
        clear_eob = 1'b1;
        cycle(0, 0, 0, 1);
        n_chk++; if (ddr_eob !== 1'b1) begin n_fail++; $display("FAIL eob_set_wins got=%0h exp=1", ddr_eob); end
        cycle(0, 0, 0, 1);
        n_chk++; if (ddr_eob !== 1'b0) begin n_fail++; $display("FAIL eob_clear got=%0h exp=0", ddr_eob); end
        clear_eob = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) cycle(1, IW'(i + 1), 0, 0);
        n_chk++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_m_tvalid got=%0h exp=1", m_tvalid); end
        n_chk++; if (m_tdata !== 32'h04030201) begin n_fail++; $display("FAIL bp_m_tdata_held got=%0h exp=04030201", m_tdata); end
`ifdef DDR_RING_BUFFER_INGRESS_DROP_EN
        n_chk++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL bp_drop_count got=%0d exp=1", drop_count); end
        n_chk++; if (data_loss !== 1'b1) begin n_fail++; $display("FAIL bp_data_loss got=%0h exp=1", data_loss); end
`else
        n_chk++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL bp_s_tready got=%0h exp=0", s_tready); end
        n_chk++; if (pack_fill !== 3'd0) begin n_fail++; $display("FAIL bp_pack_fill got=%0d exp=0", pack_fill); end
`endif
        cycle(0, 0, 0, 1);
        n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_release got=%0h exp=0", m_tvalid); end
    endtask

    task automatic test_reset_mid_word();
        cycle(1, 8'hA1, 0, 1);
        cycle(1, 8'hA2, 0, 1);
        n_chk++; if (pack_fill !== 3'd2) begin n_fail++; $display("FAIL rmid_staged got=%0d exp=2", pack_fill); end
        rst = 1'b1;
        cycle(0, 0, 0, 1);
        rst = 1'b0;
        n_chk++; if (pack_fill !== 3'd0) begin n_fail++; $display("FAIL rmid_pack_fill got=%0d exp=0", pack_fill); end
        n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_m_tvalid got=%0h exp=0", m_tvalid); end
        cycle(1, 8'hB1, 0, 1);
        cycle(1, 8'hB2, 0, 1);
        cycle(1, 8'hB3, 0, 1);
        n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_stale_word got=%0h exp=0", m_tvalid); end
        cycle(1, 8'hB4, 0, 1);
        n_chk++; if (m_tdata !== 32'hB4B3B2B1) begin n_fail++; $display("FAIL rmid_word got=%0h exp=b4b3b2b1", m_tdata); end
        cycle(0, 0, 0, 1);
        n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_single_word got=%0h exp=0", m_tvalid); end
        cycle(1, 8'hC1, 1, 1);
        cycle(0, 0, 0, 1);
        soft_rst = 1'b1;
        cycle(1, 8'hC2, 0, 1);
        n_chk++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL soft_rst_s_tready got=%0h exp=0", s_tready); end
        soft_rst = 1'b0;
        n_chk++; if (ddr_eob !== 1'b0) begin n_fail++; $display("FAIL soft_rst_ddr_eob got=%0h exp=0", ddr_eob); end
        n_chk++; if (pack_fill !== 3'd0) begin n_fail++; $display("FAIL soft_rst_pack_fill got=%0d exp=0", pack_fill); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < R; i++) cycle(1, IW'(i + 8'h60), 0, 1);
        force dut.write_offset = 32'hFFFF_FFFF;
        #1;
        release dut.write_offset;
        cycle(0, 0, 0, 1);
        n_chk++; if (write_offset !== 32'd0) begin n_fail++; $display("FAIL wrap_write_offset got=%0h exp=0", write_offset); end
        for (int i = 0; i < R; i++) cycle(1, IW'(i), 0, 1);
        cycle(0, 0, 0, 1);
        n_chk++; if (write_offset !== 32'd1) begin n_fail++; $display("FAIL wrap_next got=%0h exp=1", write_offset); end
    endtask

    task automatic test_random();
        logic [IW-1:0] staged[$];
        logic [AW:0]   outq[$];
        logic [AW:0]   w;
        logic [31:0]   exp_off;
        logic          exp_eob, exp_rdy, full, v, l, r;
        int            drops;
        logic [IW-1:0] d;
        rst = 1'b1;
        cycle(0, 0, 0, 0);
        rst = 1'b0;
        exp_off = 0; exp_eob = 0; drops = 0;
        for (int c = 0; c < 600; c++) begin
            full = outq.size() > 0;
            n_chk++; if (m_tvalid !== full) begin n_fail++; $display("FAIL rnd_m_tvalid cyc=%0d got=%0h exp=%0h", c, m_tvalid, full); end
            if (full) begin
                n_chk++; if ({m_tlast, m_tdata} !== outq[0]) begin n_fail++; $display("FAIL rnd_word cyc=%0d got=%0h exp=%0h", c, {m_tlast, m_tdata}, outq[0]); end
            end
            n_chk++; if (pack_fill !== FW'(staged.size())) begin n_fail++; $display("FAIL rnd_pack_fill cyc=%0d got=%0d exp=%0d", c, pack_fill, staged.size()); end
            n_chk++; if (write_offset !== exp_off) begin n_fail++; $display("FAIL rnd_write_offset cyc=%0d got=%0h exp=%0h", c, write_offset, exp_off); end
            n_chk++; if (ddr_eob !== exp_eob) begin n_fail++; $display("FAIL rnd_ddr_eob cyc=%0d got=%0h exp=%0h", c, ddr_eob, exp_eob); end
            n_chk++; if (drop_count !== DW'(drops)) begin n_fail++; $display("FAIL rnd_drop_count cyc=%0d got=%0d exp=%0d", c, drop_count, drops); end
            v = $urandom_range(3) != 0;
            l = $urandom_range(4) == 0;
            r = $urandom_range(2) != 0;
            d = IW'($urandom);
            clear_eob = $urandom_range(7) == 0;
            s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = r;
            #1;
`ifdef DDR_RING_BUFFER_INGRESS_DROP_EN
            exp_rdy = 1'b1;
`else
            exp_rdy = !full || r;
`endif
            n_chk++; if (s_tready !== exp_rdy) begin n_fail++; $display("FAIL rnd_s_tready cyc=%0d got=%0h exp=%0h", c, s_tready, exp_rdy); end
            if (full && r) begin
                exp_off = outq[0][AW] ? 32'd0 : exp_off + 32'd1;
                if (outq[0][AW]) exp_eob = 1'b1;
                else if (clear_eob) exp_eob = 1'b0;
                void'(outq.pop_front());
            end else if (clear_eob) exp_eob = 1'b0;
            if (v && exp_rdy) begin
                staged.push_back(d);
                if (l || staged.size() == R) begin
                    w = '0;
                    for (int k = 0; k < staged.size(); k++) w = w | ((AW + 1)'(staged[k]) << (k * IW));
                    w[AW] = l;
                    staged.delete();
                    if (full && !r) drops = drops + 1;
                    else outq.push_back(w);
                end
            end
            @(negedge clk);
        end
        clear_eob = 1'b0;
        s_tvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; soft_rst = 1'b0; clear_eob = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
        @(negedge clk);
        test_reset();
        test_pack();
        test_tlast();
        test_eob_clear();
        test_backpressure();
        test_reset_mid_word();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr_ring_buffer_ingress.md
DDR_RING_BUFFER_INGRESS -- requirements
Module: ddr_ring_buffer_ingress

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, meaning the packed output word width.
REQ-002 SHALL have parameter IN_WIDTH, default 8, meaning the input beat width; AXI_DATA_WIDTH/IN_WIDTH = R, integer and >= 2.
REQ-003 SHALL have parameter DROP_CNT_WIDTH, default 16, meaning the drop counter width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have port soft_rst, input, 1, meaning synchronous active-high datapath flush.
REQ-007 SHALL have ports s_tdata, s_tvalid, s_tlast (inputs; IN_WIDTH, 1, 1) and s_tready (output, 1), meaning the input stream.
REQ-008 SHALL have ports m_tdata, m_tvalid, m_tlast (outputs; AXI_DATA_WIDTH, 1, 1) and m_tready (input, 1), meaning the packed stream toward the ring buffer core.
REQ-009 SHALL have port write_offset, output, 32, meaning words handed over since the last end-of-block.
REQ-010 SHALL have ports ddr_eob (output, 1) and clear_eob (input, 1), meaning the sticky end-of-block flag and its clear.
REQ-011 SHALL have ports data_loss (output, 1) and drop_count (output, DROP_CNT_WIDTH), meaning overflow status.
REQ-012 SHALL have port pack_fill, output, $clog2(R)+1, meaning the number of lanes currently staged.

Function
REQ-013 SHALL place the beat accepted at lane k in m_tdata bits [k*IN_WIDTH +: IN_WIDTH], lane 0 first (little-endian).
REQ-014 SHALL complete a word when lane R-1 is accepted or s_tlast is accepted; unfilled lanes are zero-padded and the lane counter returns to 0.
REQ-015 SHALL drive the output register through two states: IDLE (m_tvalid=0) and VALID (m_tvalid=1).
REQ-016 SHALL move IDLE->VALID on word completion, stay VALID on completion with m_tready=1, move VALID->IDLE on m_tready=1 without completion, and hold VALID otherwise.
REQ-017 SHALL have a latency of 1 cycle from the completing input handshake to m_tvalid; no bubble on back-to-back words with m_tready held at 1.
REQ-018 SHALL hold m_tdata and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-019 SHALL set m_tlast equal to the s_tlast of the completing beat.
REQ-020 SHALL drive s_tready = !m_tvalid | m_tready (backpressure mode) and never make it depend on s_tvalid.
REQ-021 SHALL increment write_offset by 1 (modulo 2^32) on each m-side handshake, and load it to 0 on a handshake with m_tlast=1.
REQ-022 SHALL set ddr_eob on an m-side handshake with m_tlast=1 and clear it on clear_eob=1; on a simultaneous set and clear, set wins.
REQ-023 SHALL drive pack_fill with the staged lane count 0..R-1.
REQ-024 SHALL make soft_rst have the same effect as rst on all state, including staged lanes, the output register, counters and flags.

Reset
REQ-025 SHALL produce, on rst or soft_rst, the values m_tvalid=0, m_tdata=0, m_tlast=0, pack_fill=0, write_offset=0, ddr_eob=0, data_loss=0 and drop_count=0.
REQ-026 SHALL drive s_tready=0 during reset, and drive it per REQ-020 or REQ-028 from the first cycle after reset.
REQ-027 SHALL discard any partially staged word when reset is asserted mid-word, with no output emitted for it.

Configuration
REQ-028 SHALL, when macro DDR_RING_BUFFER_INGRESS_DROP_EN is defined, hold s_tready at 1 after reset; a word completed while VALID and m_tready=0 is discarded, drop_count increments and saturates at all-ones, and data_loss sets sticky until reset.
REQ-029 SHALL, when DDR_RING_BUFFER_INGRESS_DROP_EN is not defined, use backpressure per REQ-020 and tie data_loss and drop_count to 0.

Structure
REQ-030 SHALL place in package ddr_ring_buffer_pkg the output-state enum (IDLE, VALID) and a function computing R and the pack_fill width.
REQ-031 SHALL implement lane accumulation (staging, lane counter, zero-pad) in sub-module ddr_ring_buffer_ingress_packer; output register, FSM, counters and flags stay in the top.

Verification
REQ-032 SHALL cover, with R=4, m_tready=1: input beats 0x11,0x22,0x33,0x44 -> m_tdata=0x44332211 one cycle after the 4th beat, m_tlast=0, write_offset=1.
REQ-033 SHALL cover: beats 0xAA, 0xBB with s_tlast on 0xBB -> m_tdata=0x0000BBAA, m_tlast=1; after the handshake write_offset=0 and ddr_eob=1.
REQ-034 SHALL cover: ddr_eob=1, then clear_eob in the same cycle as a new tlast handshake -> ddr_eob remains 1; clear_eob alone -> 0 next cycle.
REQ-035 SHALL cover: m_tready=0 and 8 beats streamed -> backpressure build: s_tready=0 after the first word, m_tdata held; DROP_EN build: drop_count=1, data_loss=1.
REQ-036 SHALL cover: rst after 2 staged beats -> pack_fill=0 and m_tvalid=0; the next 4 beats produce exactly one word containing only those beats.
REQ-037 SHALL cover: 2^32-1 handshakes with write_offset preloaded by force, then one more handshake -> write_offset wraps to 0.
